// File: rtl/mc_control_unit.sv
// Multicycle MIPS controller: sequences IF/ID/EXE/MEM/WB and decodes the IR opcode
// into the datapath selects, ALU function and state-gated write/read strobes.
module mc_control_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegWre,
    output logic       RegDst,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       ExtSel,
    output logic [1:0] PCSrc
);

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_L = 3'b010,
        S_MEM   = 3'b011,
        S_WB_L  = 3'b100,
        S_EXE_B = 3'b101,
        S_EXE_A = 3'b110,
        S_WB_A  = 3'b111
    } state_t;

    state_t state_r;
    state_t next_s;
    logic   is_alu_s;
    logic   is_lw_s;
    logic   is_sw_s;
    logic   is_beq_s;
    logic   is_j_s;
    logic   is_halt_s;
    logic   is_undef_s;

    // Static opcode decode: selects, ALU function and instruction class
    always_comb begin
        ALUOp      = 3'b000;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        ExtSel     = 1'b0;
        RegDst     = 1'b0;
        DBDataSrc  = 1'b0;
        is_alu_s   = 1'b0;
        is_lw_s    = 1'b0;
        is_sw_s    = 1'b0;
        is_beq_s   = 1'b0;
        is_j_s     = 1'b0;
        is_halt_s  = 1'b0;
        is_undef_s = 1'b0;
        case (opcode)
            6'b000000: begin is_alu_s = 1'b1; RegDst = 1'b1; end
            6'b000001: begin is_alu_s = 1'b1; RegDst = 1'b1; ALUOp = 3'b001; end
            6'b000010: begin is_alu_s = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; end
            6'b010000: begin is_alu_s = 1'b1; RegDst = 1'b1; ALUOp = 3'b101; end
            6'b010001: begin is_alu_s = 1'b1; RegDst = 1'b1; ALUOp = 3'b110; end
            6'b010010: begin is_alu_s = 1'b1; ALUSrcB = 1'b1; ALUOp = 3'b101; end
            6'b011000: begin is_alu_s = 1'b1; RegDst = 1'b1; ALUSrcA = 1'b1; ALUOp = 3'b100; end
            6'b100110: begin is_alu_s = 1'b1; RegDst = 1'b1; ALUOp = 3'b010; end
            6'b110000: begin is_sw_s = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; end
            6'b110001: begin is_lw_s = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; DBDataSrc = 1'b1; end
            6'b110100: begin is_beq_s = 1'b1; ExtSel = 1'b1; ALUOp = 3'b001; end
            6'b111000: is_j_s = 1'b1;
            6'b111111: is_halt_s = 1'b1;
            default:   is_undef_s = 1'b1;
        endcase
    end

    // Next-state selection; halt parks the controller in ID until reset
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IF:    next_s = S_ID;
            S_ID: begin
                if (is_alu_s) begin
                    next_s = S_EXE_A;
                end else if (is_beq_s) begin
                    next_s = S_EXE_B;
                end else if (is_lw_s || is_sw_s) begin
                    next_s = S_EXE_L;
                end else if (is_halt_s) begin
                    next_s = S_ID;
                end else begin
                    next_s = S_IF;
                end
            end
            S_EXE_A: next_s = S_WB_A;
            S_WB_A:  next_s = S_IF;
            S_EXE_B: next_s = S_IF;
            S_EXE_L: next_s = S_MEM;
            S_MEM:   next_s = is_lw_s ? S_WB_L : S_IF;
            S_WB_L:  next_s = S_IF;
            default: next_s = S_IF;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_s;
        end
    end

    // State-gated strobes; PCWre lands in each instruction's final cycle
    always_comb begin
        PCWre  = 1'b0;
        IRWre  = 1'b0;
        RegWre = 1'b0;
        mRD    = 1'b0;
        mWR    = 1'b0;
        PCSrc  = 2'b00;
        case (state_r)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if (is_j_s) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b10;
                end else begin
                    PCWre = is_undef_s;
                end
            end
            S_EXE_B: begin
                PCWre = 1'b1;
                PCSrc = zero ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                mRD   = is_lw_s;
                mWR   = is_sw_s;
                PCWre = is_sw_s;
            end
            S_WB_A, S_WB_L: begin
                RegWre = 1'b1;
                PCWre  = 1'b1;
            end
            default: PCWre = 1'b0;
        endcase
    end

    assign state = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: an instruction-level model builds each
// instruction's expected state walk and strobes; a negedge process compares every cycle.
module tb_mc_control_unit;

    logic       CLK;
    logic       RST;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, RegWre, RegDst, DBDataSrc, mRD, mWR, ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;

    int errors = 0;
    int checks = 0;

    logic       exp_valid = 1'b0;
    logic [2:0] exp_state;
    logic       exp_pcwre, exp_irwre, exp_regwre, exp_mrd, exp_mwr;
    logic [1:0] exp_pcsrc;

    mc_control_unit dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .ExtSel(ExtSel), .PCSrc(PCSrc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Decode table: {ALUOp[2:0], ALUSrcA, ALUSrcB, ExtSel, RegDst, DBDataSrc}
    function automatic logic [7:0] model_decode(input logic [5:0] op);
        case (op)
            6'b000000: return {3'b000, 5'b00010};
            6'b000001: return {3'b001, 5'b00010};
            6'b000010: return {3'b000, 5'b01100};
            6'b010000: return {3'b101, 5'b00010};
            6'b010001: return {3'b110, 5'b00010};
            6'b010010: return {3'b101, 5'b01000};
            6'b011000: return {3'b100, 5'b10010};
            6'b100110: return {3'b010, 5'b00010};
            6'b110000: return {3'b000, 5'b01100};
            6'b110001: return {3'b000, 5'b01101};
            6'b110100: return {3'b001, 5'b00100};
            default:   return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t: got %h, required %h", name, $time, got, want);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        logic [7:0] d;
        if (exp_valid) begin
            d = model_decode(opcode);
            check("cycle",
                  {state, PCWre, IRWre, ALUSrcA, ALUSrcB, ALUOp, RegWre, RegDst,
                   DBDataSrc, mRD, mWR, ExtSel, PCSrc},
                  {exp_state, exp_pcwre, exp_irwre, d[4], d[3], d[7:5], exp_regwre, d[1],
                   d[0], exp_mrd, exp_mwr, d[2], exp_pcsrc});
        end
    end

    task automatic set_idle_exp(input logic [2:0] st, input logic ir);
        exp_state  = st;
        exp_irwre  = ir;
        exp_pcwre  = 1'b0;
        exp_regwre = 1'b0;
        exp_mrd    = 1'b0;
        exp_mwr    = 1'b0;
        exp_pcsrc  = 2'b00;
    endtask

    // Holds reset low for n edges, then releases it; the current cycle is then IF
    task automatic do_reset(input int n);
        RST    = 1'b0;
        opcode = 6'b000000;
        set_idle_exp(3'b000, 1'b1);
        exp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
    endtask

    // Runs one instruction from its IF cycle; run_len limits how many cycles are walked
    task automatic run_instr(input logic [5:0] op, input logic z, input int extra, input int run_len);
        int  seq[5];
        int  len;
        bit  alu, lw, sw, beq, j, halt, last;
        alu  = (op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000,
                           6'b010001, 6'b010010, 6'b011000, 6'b100110});
        lw   = (op == 6'b110001);
        sw   = (op == 6'b110000);
        beq  = (op == 6'b110100);
        j    = (op == 6'b111000);
        halt = (op == 6'b111111);
        if (alu)       begin seq = '{0, 1, 6, 7, 0}; len = 4; end
        else if (lw)   begin seq = '{0, 1, 2, 3, 4}; len = 5; end
        else if (sw)   begin seq = '{0, 1, 2, 3, 0}; len = 4; end
        else if (beq)  begin seq = '{0, 1, 5, 0, 0}; len = 3; end
        else if (halt) begin seq = '{0, 1, 1, 1, 1}; len = 2 + extra; end
        else           begin seq = '{0, 1, 0, 0, 0}; len = 2; end
        for (int k = 0; k < len && (run_len == 0 || k < run_len); k++) begin
            exp_state  = 3'(seq[(k < 5) ? k : 4]);
            last       = (k == len - 1) && !halt;
            opcode     = op;
            zero       = (exp_state == 3'b101) ? z : 1'($urandom_range(0, 1));
            exp_irwre  = (k == 0);
            exp_pcwre  = last;
            exp_pcsrc  = (last && j) ? 2'b10 : ((last && beq && z) ? 2'b01 : 2'b00);
            exp_regwre = last && (alu || lw);
            exp_mrd    = lw && (k == 3);
            exp_mwr    = sw && (k == 3);
            @(posedge CLK);
            #1;
        end
        if (run_len == 0 && !halt) check("back_in_if", {15'd0, state}, 18'd0);
    endtask

    initial begin
        RST    = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        #1;
        check("reset_async", {15'd0, state, IRWre, PCWre, RegWre, mWR} >> 4, {15'd0, 3'b000});
        check("reset_strobes", {14'd0, IRWre, PCWre, RegWre, mWR}, {14'd0, 4'b1000});
        do_reset(3);

        run_instr(6'b000000, 1'b0, 0, 0);  // add
        run_instr(6'b000001, 1'b0, 0, 0);  // sub
        run_instr(6'b000010, 1'b1, 0, 0);  // addi
        run_instr(6'b010000, 1'b0, 0, 0);  // or
        run_instr(6'b010001, 1'b0, 0, 0);  // and
        run_instr(6'b010010, 1'b0, 0, 0);  // ori
        run_instr(6'b011000, 1'b0, 0, 0);  // sll
        run_instr(6'b100110, 1'b0, 0, 0);  // slt
        run_instr(6'b110001, 1'b0, 0, 0);  // lw
        run_instr(6'b110000, 1'b0, 0, 0);  // sw
        run_instr(6'b110100, 1'b1, 0, 0);  // beq taken
        run_instr(6'b110100, 1'b0, 0, 0);  // beq not taken
        run_instr(6'b111000, 1'b0, 0, 0);  // j
        run_instr(6'b101010, 1'b0, 0, 0);  // undefined
        run_instr(6'b000011, 1'b1, 0, 0);  // undefined
        run_instr(6'b111111, 1'b0, 20, 0); // halt
        check("halt_parked", {15'd0, state}, {15'd0, 3'b001});
        do_reset(2);

        // Abort an add in WB_A with an asynchronous reset between edges
        run_instr(6'b000000, 1'b0, 0, 3);
        set_idle_exp(3'b111, 1'b0);
        exp_regwre = 1'b1;
        exp_pcwre  = 1'b1;
        #5;
        check("wb_a_reached", {14'd0, state, RegWre}, {14'd0, 3'b111, 1'b1});
        RST = 1'b0;
        #1;
        check("midop_reset", {13'd0, state, RegWre, PCWre}, {13'd0, 3'b000, 2'b00});
        do_reset(2);
        run_instr(6'b110001, 1'b0, 0, 0);
        run_instr(6'b000000, 1'b0, 0, 0);

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
